l2_buf_read_responder: RTL and testbench
========================================

Name: l2_buf_read_responder

Overview:
- L2-side server for the DLA_CORE buffer-read channel (wei_buf_read_* / act_buf_read_*). The core drives ready plus address; this block returns data plus valid.
- Holds one L2 bank (weights or activations; one instance per channel).
- A fill port loads the bank from the DDR loader stream.
- Replaces the behavioural L2 arrays with synthesizable posedge RTL.

Parameters:
- DATA_W, 64, row width in bits (WEI_BUF_DATA or ACT_BUF_DATA).
- ROWS, 1024, bank depth (L2_WEI_BUF_ROWS or L2_ACT_BUF_ROWS).
- ADDR_W, $clog2(ROWS), address width.
- RD_LAT, 1, request-to-valid latency in cycles (1..4).

Ports:
- core_clk, input, 1, sole clock; all logic on posedge.
- rst, input, 1, reset: synchronous, active-high.
- buf_read_ready, input, 1, core read request (level, one read per cycle while high).
- buf_read_addr, input, ADDR_W, requested row.
- buf_read_valid, output, 1, buf_read_data is valid this cycle.
- buf_read_data, output, DATA_W, row contents.
- fill_start, input, 1, one-cycle pulse: begin a fill.
- fill_base, input, ADDR_W, first row to fill.
- fill_len, input, ADDR_W+1, rows to fill (0..ROWS).
- fill_in_valid, input, 1, DDR-side word present.
- fill_in_data, input, DATA_W, DDR-side word.
- fill_in_ready, output, 1, block accepts fill word.
- fill_busy, output, 1, fill in progress.
- fill_done, output, 1, one-cycle pulse when the last row is written.

Behaviour:
- Reset:
  - All outputs are 0 (buf_read_valid, buf_read_data, fill_in_ready, fill_busy, fill_done).
  - Fill FSM goes to IDLE and the latency pipe is flushed.
  - Memory contents are not cleared.
  - Reset mid-fill or mid-read aborts the operation with no done pulse and no valid.
- Read path:
  - A request is accepted in a cycle where buf_read_ready=1 and the request is not stalled.
  - An accepted request at cycle t gives buf_read_valid=1 with buf_read_data=mem[addr] at cycle t+RD_LAT.
  - An unaccepted cycle gives buf_read_valid=0 at t+RD_LAT. Data holds its last value when valid=0.
  - Back-to-back requests give one valid per cycle. Full throughput, no bubbles.
- Stall:
  - While fill_busy, a request is stalled if its address lies in the not-yet-written part of the fill window: modular distance (addr - wr_ptr) mod ROWS < remaining.
  - A stalled request produces no valid. The core keeps ready/addr and the request is retried next cycle.
  - Addresses outside the window are served normally during a fill.
- Read/write same cycle, same address: the write takes effect and the read returns the new fill_in_data (write-through forwarding).
- Fill FSM states:
  - IDLE:
    - fill_start with fill_len=0 pulses fill_done the next cycle and returns to IDLE.
    - fill_start with fill_len>0: wr_ptr=fill_base, remaining=fill_len, go to FILL.
    - fill_start is ignored in FILL and DONE.
  - FILL:
    - fill_busy=1 and fill_in_ready=1.
    - Each fill_in_valid cycle writes mem[wr_ptr], wr_ptr=(wr_ptr+1) mod ROWS (wraps past ROWS-1 to 0), and remaining decrements.
    - When the last word is written, go to DONE.
  - DONE: fill_done=1 and fill_busy=0 for one cycle, then IDLE.
- Width rules:
  - All address arithmetic is modulo ROWS.
  - fill_len=ROWS overwrites the whole bank.
  - Requests with buf_read_addr >= ROWS (non-power-of-2 ROWS) return 0 with valid=1.

Decomposition:
- Shared package dla_l2_pkg: fill state enum (IDLE/FILL/DONE) and the width constants mirrored from the existing `define set (WEI_BUF_DATA, ACT_BUF_DATA, L2_*_BUF_ROWS, L2_*_BUF_ROWS_LOG2).
- One sub-module, l2_sram_1r1w: registered read, one write port, no reset on the array.
- Stall, forwarding, latency pipe and FSM live in the top module.

Test Plan:
- Preload rows 0..7 = 0x10..0x17 via fill (base 0, len 8); hold ready=1 with addr 0..7 on successive cycles. Expect valid on 8 consecutive cycles with data 0x10..0x17 in order, latency exactly RD_LAT (run RD_LAT=1 and 3).
- fill_len=0 at base 5: fill_done pulses one cycle later; fill_busy never rises; memory unchanged.
- Wrap fill with ROWS=16, base 14, len 4, data A,B,C,D: rows 14,15,0,1 = A,B,C,D; rows 2..13 unchanged; done after the 4th accepted word.
- Stall: fill base 0 len 4, one word every 3 cycles, core requests addr 3 from fill start. Expect valid=0 until the cycle row 3 is written; that cycle returns forwarded D, then normal reads. A concurrent request to addr 9 is served immediately.
- Assert rst during FILL after 2 of 4 words: all outputs 0 next cycle, no fill_done, FSM in IDLE. A new fill_start is accepted afterwards.
- ROWS=10, read addr 12: valid=1, data=0. fill_start asserted during FILL is ignored (fill_base/len unchanged, single done pulse).

Source files
------------

// File: rtl/dla_l2_pkg.sv
// Shared constants for the DLA L2 buffer banks and the fill state encoding.
// Width constants mirror the legacy `define set so existing configurations carry over.
package dla_l2_pkg;

  localparam int WEI_BUF_DATA         = 64;
  localparam int ACT_BUF_DATA         = 64;
  localparam int L2_WEI_BUF_ROWS      = 1024;
  localparam int L2_ACT_BUF_ROWS      = 1024;
  localparam int L2_WEI_BUF_ROWS_LOG2 = 10;
  localparam int L2_ACT_BUF_ROWS_LOG2 = 10;

  typedef logic [1:0] fill_state_t;

  localparam fill_state_t FILL_IDLE   = 2'd0;
  localparam fill_state_t FILL_ACTIVE = 2'd1;
  localparam fill_state_t FILL_DONE   = 2'd2;

  typedef logic [1:0] rd_sel_t;

  localparam rd_sel_t RD_SEL_ZERO = 2'd0;
  localparam rd_sel_t RD_SEL_MEM  = 2'd1;
  localparam rd_sel_t RD_SEL_FWD  = 2'd2;

endpackage

// File: rtl/l2_sram_1r1w.sv
// One-read one-write bank with a registered read port and no reset on the array.
// A read and write to the same row in one cycle returns the old contents.
module l2_sram_1r1w #(
  parameter int DATA_W = 64,
  parameter int ROWS   = 1024,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic              i_clk,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_mem [ROWS];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/l2_buf_read_responder.sv
// L2-side responder for the core buffer-read channel, with a DDR fill port.
// Reads covering rows not yet written by an in-flight fill are held off until written.
module l2_buf_read_responder
  import dla_l2_pkg::*;
#(
  parameter int DATA_W = WEI_BUF_DATA,
  parameter int ROWS   = L2_WEI_BUF_ROWS,
  parameter int ADDR_W = $clog2(ROWS),
  parameter int RD_LAT = 1
) (
  input  logic              i_core_clk,
  input  logic              i_rst,
  input  logic              i_buf_read_ready,
  input  logic [ADDR_W-1:0] i_buf_read_addr,
  output logic              o_buf_read_valid,
  output logic [DATA_W-1:0] o_buf_read_data,
  input  logic              i_fill_start,
  input  logic [ADDR_W-1:0] i_fill_base,
  input  logic [ADDR_W:0]   i_fill_len,
  input  logic              i_fill_in_valid,
  input  logic [DATA_W-1:0] i_fill_in_data,
  output logic              o_fill_in_ready,
  output logic              o_fill_busy,
  output logic              o_fill_done
);

  localparam logic [ADDR_W:0]   L_ROWS = (ADDR_W+1)'(ROWS);
  localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(ROWS - 1);

  fill_state_t       r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_s1_valid;
  rd_sel_t           r_s1_sel;
  logic [DATA_W-1:0] r_s1_fwd;
  logic [DATA_W-1:0] w_mem_data;
  logic [DATA_W-1:0] w_s1_data;
  logic              w_busy;
  logic              w_wr_en;
  logic              w_addr_oor;
  logic              w_fwd_hit;
  logic              w_stall;
  logic              w_accept;
  logic [ADDR_W:0]   w_dist;

  assign w_busy     = (r_state == FILL_ACTIVE);
  assign w_wr_en    = w_busy && i_fill_in_valid && !i_rst;
  assign w_addr_oor = ({1'b0, i_buf_read_addr} >= L_ROWS);
  assign w_fwd_hit  = w_wr_en && (i_buf_read_addr == r_wr_ptr);

  // Modular distance from the write pointer; below remaining means not yet written.
  assign w_dist = (i_buf_read_addr >= r_wr_ptr)
                ? ({1'b0, i_buf_read_addr} - {1'b0, r_wr_ptr})
                : ({1'b0, i_buf_read_addr} + L_ROWS - {1'b0, r_wr_ptr});

  assign w_stall  = w_busy && !w_addr_oor && (w_dist < r_remaining) && !w_fwd_hit;
  assign w_accept = i_buf_read_ready && !w_stall && !i_rst;

  assign o_fill_busy     = w_busy;
  assign o_fill_in_ready = w_busy;
  assign o_fill_done     = (r_state == FILL_DONE);

  l2_sram_1r1w #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .i_clk     (i_core_clk),
    .i_rd_en   (w_accept && !w_addr_oor && !w_fwd_hit),
    .i_rd_addr (i_buf_read_addr),
    .o_rd_data (w_mem_data),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_fill_in_data)
  );

  always_ff @(posedge i_core_clk) begin
    if (i_rst) begin
      r_state     <= FILL_IDLE;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        FILL_IDLE: begin
          if (i_fill_start) begin
            r_wr_ptr    <= i_fill_base;
            r_remaining <= i_fill_len;
            r_state     <= (i_fill_len == '0) ? FILL_DONE : FILL_ACTIVE;
          end
        end
        FILL_ACTIVE: begin
          if (i_fill_in_valid) begin
            r_wr_ptr    <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - (ADDR_W+1)'(1);
            if (r_remaining == (ADDR_W+1)'(1)) r_state <= FILL_DONE;
          end
        end
        FILL_DONE: r_state <= FILL_IDLE;
        default:   r_state <= FILL_IDLE;
      endcase
    end
  end

  // Select and forward bits only move on an accepted read so idle cycles hold the data.
  always_ff @(posedge i_core_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sel   <= RD_SEL_ZERO;
      r_s1_fwd   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        if (w_addr_oor) begin
          r_s1_sel <= RD_SEL_ZERO;
        end else if (w_fwd_hit) begin
          r_s1_sel <= RD_SEL_FWD;
          r_s1_fwd <= i_fill_in_data;
        end else begin
          r_s1_sel <= RD_SEL_MEM;
        end
      end
    end
  end

  always_comb begin
    w_s1_data = '0;
    case (r_s1_sel)
      RD_SEL_MEM: w_s1_data = w_mem_data;
      RD_SEL_FWD: w_s1_data = r_s1_fwd;
      default:    w_s1_data = '0;
    endcase
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign o_buf_read_valid = r_s1_valid;
      assign o_buf_read_data  = w_s1_data;
    end else begin : g_latn
      logic [RD_LAT-2:0] r_pipe_valid;
      logic [DATA_W-1:0] r_pipe_data [RD_LAT-1];

      always_ff @(posedge i_core_clk) begin
        if (i_rst) begin
          r_pipe_valid <= '0;
          for (int i = 0; i < RD_LAT-1; i++) r_pipe_data[i] <= '0;
        end else begin
          r_pipe_valid[0] <= r_s1_valid;
          if (r_s1_valid) r_pipe_data[0] <= w_s1_data;
          for (int i = 1; i < RD_LAT-1; i++) begin
            r_pipe_valid[i] <= r_pipe_valid[i-1];
            if (r_pipe_valid[i-1]) r_pipe_data[i] <= r_pipe_data[i-1];
          end
        end
      end

      assign o_buf_read_valid = r_pipe_valid[RD_LAT-2];
      assign o_buf_read_data  = r_pipe_data[RD_LAT-2];
    end
  endgenerate

endmodule

// File: tb/tb_l2_buf_read_responder.sv
// Directed bench: three responders (16 rows lat 1, 16 rows lat 3, 10 rows lat 1) share stimulus.
// The 10-row instance only sees fill_start while cEnable is set, keeping its fills in range.
module tb_l2_buf_read_responder;

  localparam int DW = 64;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdReady;
  logic [AW-1:0] rdAddr;
  logic          fillStart;
  logic          cEnable;
  logic [AW-1:0] fillBase;
  logic [AW:0]   fillLen;
  logic          fillInValid;
  logic [DW-1:0] fillInData;

  logic          aValid, bValid, cValid;
  logic [DW-1:0] aData, bData, cData;
  logic          aInReady, bInReady, cInReady;
  logic          aBusy, bBusy, cBusy;
  logic          aDone, bDone, cDone;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  l2_buf_read_responder #(.DATA_W(DW), .ROWS(16), .ADDR_W(AW), .RD_LAT(1)) dutA (
    .i_core_clk(clk), .i_rst(rst), .i_buf_read_ready(rdReady), .i_buf_read_addr(rdAddr),
    .o_buf_read_valid(aValid), .o_buf_read_data(aData), .i_fill_start(fillStart),
    .i_fill_base(fillBase), .i_fill_len(fillLen), .i_fill_in_valid(fillInValid),
    .i_fill_in_data(fillInData), .o_fill_in_ready(aInReady), .o_fill_busy(aBusy),
    .o_fill_done(aDone));

  l2_buf_read_responder #(.DATA_W(DW), .ROWS(16), .ADDR_W(AW), .RD_LAT(3)) dutB (
    .i_core_clk(clk), .i_rst(rst), .i_buf_read_ready(rdReady), .i_buf_read_addr(rdAddr),
    .o_buf_read_valid(bValid), .o_buf_read_data(bData), .i_fill_start(fillStart),
    .i_fill_base(fillBase), .i_fill_len(fillLen), .i_fill_in_valid(fillInValid),
    .i_fill_in_data(fillInData), .o_fill_in_ready(bInReady), .o_fill_busy(bBusy),
    .o_fill_done(bDone));

  l2_buf_read_responder #(.DATA_W(DW), .ROWS(10), .ADDR_W(AW), .RD_LAT(1)) dutC (
    .i_core_clk(clk), .i_rst(rst), .i_buf_read_ready(rdReady), .i_buf_read_addr(rdAddr),
    .o_buf_read_valid(cValid), .o_buf_read_data(cData), .i_fill_start(fillStart && cEnable),
    .i_fill_base(fillBase), .i_fill_len(fillLen), .i_fill_in_valid(fillInValid),
    .i_fill_in_data(fillInData), .o_fill_in_ready(cInReady), .o_fill_busy(cBusy),
    .o_fill_done(cDone));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startFill(input logic [AW-1:0] base, input logic [AW:0] len);
    fillStart = 1'b1;
    fillBase  = base;
    fillLen   = len;
    tick();
    fillStart = 1'b0;
  endtask

  task automatic pushWord(input logic [DW-1:0] data);
    fillInValid = 1'b1;
    fillInData  = data;
    tick();
    fillInValid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checkCount++;
    if ({aValid, aData, aInReady, aBusy, aDone} !== '0)
      $display("[TB] FAIL reset_a got v=%b d=%h r=%b b=%b dn=%b want all 0", aValid, aData, aInReady, aBusy, aDone);
    else passCount++;
    checkCount++;
    if ({bValid, bData, bInReady, bBusy, bDone} !== '0)
      $display("[TB] FAIL reset_b got v=%b d=%h r=%b b=%b dn=%b want all 0", bValid, bData, bInReady, bBusy, bDone);
    else passCount++;
    checkCount++;
    if ({cValid, cData, cInReady, cBusy, cDone} !== '0)
      $display("[TB] FAIL reset_c got v=%b d=%h r=%b b=%b dn=%b want all 0", cValid, cData, cInReady, cBusy, cDone);
    else passCount++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_burst_read();
    logic          expV;
    logic [DW-1:0] expD;
    int            j;
    startFill(4'd0, 5'd8);
    for (int i = 0; i < 8; i++) pushWord(DW'(64'h10 + i));
    checkCount++;
    if (aDone !== 1'b1) $display("[TB] FAIL burst_fill_done got %b want 1", aDone);
    else passCount++;
    tick();
    for (int c = 0; c < 11; c++) begin
      rdReady = (c < 8);
      rdAddr  = (c < 8) ? AW'(c) : '0;
      tick();
      expV = (c < 8);
      expD = (c < 8) ? DW'(64'h10 + c) : DW'(64'h17);
      checkCount++;
      if ({aValid, aData} !== {expV, expD})
        $display("[TB] FAIL burst_lat1 c=%0d got v=%b d=%h want v=%b d=%h", c, aValid, aData, expV, expD);
      else passCount++;
      checkCount++;
      if ({cValid, cData} !== {expV, expD})
        $display("[TB] FAIL burst_rows10 c=%0d got v=%b d=%h want v=%b d=%h", c, cValid, cData, expV, expD);
      else passCount++;
      j = c - 2;
      checkCount++;
      if (j >= 0 && j < 8) begin
        if ({bValid, bData} !== {1'b1, DW'(64'h10 + j)})
          $display("[TB] FAIL burst_lat3 c=%0d got v=%b d=%h want v=1 d=%h", c, bValid, bData, DW'(64'h10 + j));
        else passCount++;
      end else begin
        if (bValid !== 1'b0) $display("[TB] FAIL burst_lat3_idle c=%0d got v=%b want 0", c, bValid);
        else passCount++;
      end
    end
    rdReady = 1'b0;
  endtask

  task automatic test_zero_len();
    fillStart = 1'b1;
    fillBase  = 4'd5;
    fillLen   = 5'd0;
    tick();
    fillStart = 1'b0;
    checkCount++;
    if ({aBusy, aDone} !== 2'b01) $display("[TB] FAIL zero_len_done got busy=%b done=%b want 0 1", aBusy, aDone);
    else passCount++;
    tick();
    checkCount++;
    if ({aBusy, aDone} !== 2'b00) $display("[TB] FAIL zero_len_after got busy=%b done=%b want 0 0", aBusy, aDone);
    else passCount++;
    rdReady = 1'b1;
    rdAddr  = 4'd5;
    tick();
    rdReady = 1'b0;
    checkCount++;
    if ({aValid, aData} !== {1'b1, DW'(64'h15)})
      $display("[TB] FAIL zero_len_mem got v=%b d=%h want v=1 d=15", aValid, aData);
    else passCount++;
  endtask

  task automatic test_wrap_fill();
    logic [AW-1:0] addrs [6] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd7};
    logic [DW-1:0] exps  [6] = '{64'hA, 64'hB, 64'hC, 64'hD, 64'h12, 64'h17};
    cEnable = 1'b0;
    startFill(4'd14, 5'd4);
    for (int i = 0; i < 4; i++) begin
      pushWord(DW'(64'hA + i));
      checkCount++;
      if (aDone !== (i == 3)) $display("[TB] FAIL wrap_done word=%0d got %b want %b", i, aDone, (i == 3));
      else passCount++;
    end
    tick();
    cEnable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rdReady = 1'b1;
      rdAddr  = addrs[i];
      tick();
      checkCount++;
      if ({aValid, aData} !== {1'b1, exps[i]})
        $display("[TB] FAIL wrap_row%0d got v=%b d=%h want v=1 d=%h", addrs[i], aValid, aData, exps[i]);
      else passCount++;
    end
    rdReady = 1'b0;
  endtask

  task automatic test_stall();
    logic expV;
    startFill(4'd0, 5'd4);
    rdReady = 1'b1;
    rdAddr  = 4'd7;
    tick();
    checkCount++;
    if ({aBusy, aValid, aData} !== {1'b1, 1'b1, DW'(64'h17)})
      $display("[TB] FAIL stall_outside got busy=%b v=%b d=%h want 1 1 17", aBusy, aValid, aData);
    else passCount++;
    rdAddr = 4'd3;
    for (int n = 0; n < 14; n++) begin
      fillInValid = (n % 3 == 2) && (n <= 11);
      fillInData  = DW'(64'h20 + n / 3);
      tick();
      expV = (n >= 11);
      checkCount++;
      if (expV) begin
        if ({aValid, aData} !== {1'b1, DW'(64'h23)})
          $display("[TB] FAIL stall_release n=%0d got v=%b d=%h want v=1 d=23", n, aValid, aData);
        else passCount++;
      end else begin
        if (aValid !== 1'b0) $display("[TB] FAIL stall_hold n=%0d got v=%b want 0", n, aValid);
        else passCount++;
      end
      if (n == 11) begin
        checkCount++;
        if (aDone !== 1'b1) $display("[TB] FAIL stall_done got %b want 1", aDone);
        else passCount++;
      end
    end
    fillInValid = 1'b0;
    rdAddr      = 4'd1;
    tick();
    rdReady = 1'b0;
    checkCount++;
    if ({aValid, aData} !== {1'b1, DW'(64'h21)})
      $display("[TB] FAIL stall_row1 got v=%b d=%h want v=1 d=21", aValid, aData);
    else passCount++;
  endtask

  task automatic test_reset_mid_fill();
    int doneSeen;
    startFill(4'd4, 5'd4);
    pushWord(DW'(64'h30));
    pushWord(DW'(64'h31));
    rst         = 1'b1;
    rdReady     = 1'b1;
    rdAddr      = 4'd0;
    fillInValid = 1'b1;
    fillInData  = DW'(64'h99);
    tick();
    rst         = 1'b0;
    rdReady     = 1'b0;
    fillInValid = 1'b0;
    checkCount++;
    if ({aValid, aData, aInReady, aBusy, aDone} !== '0)
      $display("[TB] FAIL midfill_reset_a got v=%b d=%h r=%b b=%b dn=%b want all 0", aValid, aData, aInReady, aBusy, aDone);
    else passCount++;
    checkCount++;
    if ({bValid, bData, bInReady, bBusy, bDone} !== '0)
      $display("[TB] FAIL midfill_reset_b got v=%b d=%h r=%b b=%b dn=%b want all 0", bValid, bData, bInReady, bBusy, bDone);
    else passCount++;
    doneSeen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (aDone || aBusy) doneSeen++;
    end
    checkCount++;
    if (doneSeen !== 0) $display("[TB] FAIL midfill_no_done got %0d busy/done cycles want 0", doneSeen);
    else passCount++;
    startFill(4'd6, 5'd1);
    checkCount++;
    if (aBusy !== 1'b1) $display("[TB] FAIL midfill_restart got busy=%b want 1", aBusy);
    else passCount++;
    pushWord(DW'(64'h44));
    checkCount++;
    if (aDone !== 1'b1) $display("[TB] FAIL midfill_restart_done got %b want 1", aDone);
    else passCount++;
    rdReady = 1'b1;
    rdAddr  = 4'd4;
    tick();
    checkCount++;
    if ({aValid, aData} !== {1'b1, DW'(64'h30)})
      $display("[TB] FAIL midfill_row4 got v=%b d=%h want v=1 d=30", aValid, aData);
    else passCount++;
    rdAddr = 4'd6;
    tick();
    checkCount++;
    if ({aValid, aData} !== {1'b1, DW'(64'h44)})
      $display("[TB] FAIL midfill_row6 got v=%b d=%h want v=1 d=44", aValid, aData);
    else passCount++;
    rdReady = 1'b0;
  endtask

  task automatic test_out_of_range();
    rdReady = 1'b1;
    rdAddr  = 4'd6;
    tick();
    checkCount++;
    if ({cValid, cData} !== {1'b1, DW'(64'h44)})
      $display("[TB] FAIL oor_prior got v=%b d=%h want v=1 d=44", cValid, cData);
    else passCount++;
    rdAddr = 4'd12;
    tick();
    rdReady = 1'b0;
    checkCount++;
    if ({cValid, cData} !== {1'b1, DW'(0)})
      $display("[TB] FAIL oor_addr12 got v=%b d=%h want v=1 d=0", cValid, cData);
    else passCount++;
  endtask

  task automatic test_start_ignored();
    int doneSeen;
    startFill(4'd0, 5'd2);
    fillStart   = 1'b1;
    fillBase    = 4'd8;
    fillLen     = 5'd5;
    fillInValid = 1'b1;
    fillInData  = DW'(64'h50);
    tick();
    fillStart   = 1'b0;
    fillInValid = 1'b0;
    checkCount++;
    if ({aBusy, aDone} !== 2'b10) $display("[TB] FAIL ignore_mid got busy=%b done=%b want 1 0", aBusy, aDone);
    else passCount++;
    pushWord(DW'(64'h51));
    checkCount++;
    if ({aBusy, aDone} !== 2'b01) $display("[TB] FAIL ignore_done got busy=%b done=%b want 0 1", aBusy, aDone);
    else passCount++;
    doneSeen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (aDone || aBusy) doneSeen++;
    end
    checkCount++;
    if (doneSeen !== 0) $display("[TB] FAIL ignore_single_done got %0d extra busy/done cycles want 0", doneSeen);
    else passCount++;
    rdReady = 1'b1;
    rdAddr  = 4'd1;
    tick();
    rdReady = 1'b0;
    checkCount++;
    if ({aValid, aData} !== {1'b1, DW'(64'h51)})
      $display("[TB] FAIL ignore_row1 got v=%b d=%h want v=1 d=51", aValid, aData);
    else passCount++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst         = 1'b0;
    rdReady     = 1'b0;
    rdAddr      = '0;
    fillStart   = 1'b0;
    cEnable     = 1'b1;
    fillBase    = '0;
    fillLen     = '0;
    fillInValid = 1'b0;
    fillInData  = '0;
    #2;
    $display("[TB] starting l2_buf_read_responder directed tests");
    test_reset();
    test_burst_read();
    test_zero_len();
    test_wrap_fill();
    test_stall();
    test_reset_mid_fill();
    test_out_of_range();
    test_start_ignored();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
